// File: rtl/sig_dump_ctrl.sv
// sig_dump_ctrl: memory-mapped signature dump controller.
//
// Software programs BEGIN/END, then writes CTRL.start. The block reads the
// region [BEGIN, END) one word at a time through its host port and presents
// each word, with its address, on the sig_* stream to the simulator harness.
// When the dump completes it sets STATUS.done and, if requested, a sticky halt.
//
// Register map (dev_addr_i[9:2]):
//   0x00 BEGIN   RW  (bits [1:0] always read 0)
//   0x04 END     RW  (bits [1:0] always read 0)
//   0x08 CTRL    W   bit0 start, bit1 halt_on_done; reads 0
//   0x0C STATUS  RO  bit0 busy, bit1 done
//   0x10 CHECKSUM RO (only with SIG_DUMP_CHECKSUM_EN): wrap-around sum of
//        every word accepted on the sig handshake, cleared on start.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   dev_*                    slave port; response one cycle after each request
//   host_*                   read host port to RAM, one outstanding read max
//   sig_valid_o/ready_i      signature word stream (addr + data)
//   busy_o, halt_o           dump in progress, sticky end-of-simulation request
//
// Optional feature macro: SIG_DUMP_CHECKSUM_EN.

module sig_dump_ctrl #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 dev_req_i,
  input  logic                 dev_we_i,
  input  logic [AddrWidth-1:0] dev_addr_i,
  input  logic [3:0]           dev_be_i,
  input  logic [DataWidth-1:0] dev_wdata_i,
  output logic                 dev_rvalid_o,
  output logic [DataWidth-1:0] dev_rdata_o,
  output logic                 dev_err_o,
  output logic                 host_req_o,
  input  logic                 host_gnt_i,
  output logic [AddrWidth-1:0] host_addr_o,
  input  logic                 host_rvalid_i,
  input  logic [DataWidth-1:0] host_rdata_i,
  output logic                 sig_valid_o,
  input  logic                 sig_ready_i,
  output logic [AddrWidth-1:0] sig_addr_o,
  output logic [DataWidth-1:0] sig_data_o,
  output logic                 busy_o,
  output logic                 halt_o
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, PUSH, DONE} state_e;
  state_e state_q, state_d;

  logic [AddrWidth-1:0] begin_q, end_q, cur_q, cur_inc, sig_addr_q;
  logic [DataWidth-1:0] sig_data_q, rdata_c, dev_rdata_q;
  logic                 halt_on_done_q, done_q, halt_q, dev_rvalid_q, dev_err_q;
  logic                 busy, err_c, wr_ok, start, hod_eff;
  logic [7:0]           word_off;
  logic                 sel_begin, sel_end, sel_ctrl, sel_status, sel_csum, mapped;
  logic                 unused_addr_bits;

`ifdef SIG_DUMP_CHECKSUM_EN
  logic [DataWidth-1:0] csum_q;
`endif

  assign word_off   = dev_addr_i[9:2];
  assign sel_begin  = (word_off == 8'h00);
  assign sel_end    = (word_off == 8'h01);
  assign sel_ctrl   = (word_off == 8'h02);
  assign sel_status = (word_off == 8'h03);
`ifdef SIG_DUMP_CHECKSUM_EN
  assign sel_csum   = (word_off == 8'h04);
`else
  assign sel_csum   = 1'b0;
`endif
  assign mapped     = sel_begin | sel_end | sel_ctrl | sel_status | sel_csum;

  // Address bits outside the 1 kB window and the byte lane are not decoded.
  assign unused_addr_bits = ^{dev_addr_i[AddrWidth-1:10], dev_addr_i[1:0]};

  assign busy  = (state_q != IDLE);

  // BEGIN/END are frozen while a dump runs so the walk cannot be retargeted.
  assign err_c = ~mapped |
                 (dev_we_i & ((dev_be_i != 4'hF) | sel_status | sel_csum |
                              ((sel_begin | sel_end) & busy)));
  assign wr_ok = dev_req_i & dev_we_i & ~err_c;

  // A start while busy is silently dropped (no error).
  assign start   = wr_ok & sel_ctrl & dev_wdata_i[0] & ~busy;
  // An empty region goes IDLE->DONE directly, so the halt flag being latched
  // in that same cycle must be used immediately.
  assign hod_eff = start ? dev_wdata_i[1] : halt_on_done_q;
  assign cur_inc = cur_q + AddrWidth'(4);

  // Read data reflects register state before this cycle's updates.
  always_comb begin
    rdata_c = '0;
    if (dev_req_i && !dev_we_i && !err_c) begin
      if (sel_begin)       rdata_c = DataWidth'(begin_q);
      else if (sel_end)    rdata_c = DataWidth'(end_q);
      else if (sel_status) rdata_c = DataWidth'({done_q, busy});
`ifdef SIG_DUMP_CHECKSUM_EN
      else if (sel_csum)   rdata_c = csum_q;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    host_req_o  = 1'b0;
    host_addr_o = '0;
    sig_valid_o = 1'b0;
    unique case (state_q)
      IDLE: if (start) state_d = (begin_q < end_q) ? REQ : DONE;
      REQ: begin
        host_req_o  = 1'b1;
        host_addr_o = cur_q;
        if (host_gnt_i) state_d = WAIT;
      end
      WAIT: if (host_rvalid_i) state_d = PUSH;
      PUSH: begin
        sig_valid_o = 1'b1;
        if (sig_ready_i) state_d = (cur_inc >= end_q) ? DONE : REQ;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      begin_q        <= '0;
      end_q          <= '0;
      cur_q          <= '0;
      sig_addr_q     <= '0;
      sig_data_q     <= '0;
      halt_on_done_q <= 1'b0;
      done_q         <= 1'b0;
      halt_q         <= 1'b0;
      dev_rvalid_q   <= 1'b0;
      dev_err_q      <= 1'b0;
      dev_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      dev_rvalid_q <= dev_req_i;
      dev_err_q    <= dev_req_i & err_c;
      dev_rdata_q  <= rdata_c;
      if (wr_ok && sel_begin) begin_q <= AddrWidth'(dev_wdata_i) & ~AddrWidth'(3);
      if (wr_ok && sel_end)   end_q   <= AddrWidth'(dev_wdata_i) & ~AddrWidth'(3);
      if (start) begin
        halt_on_done_q <= dev_wdata_i[1];
        done_q         <= 1'b0;
        cur_q          <= begin_q;
      end
      if (state_q == WAIT && host_rvalid_i) begin
        sig_data_q <= host_rdata_i;
        sig_addr_q <= cur_q;
      end
      if (state_q == PUSH && sig_ready_i) cur_q <= cur_inc;
      // done/halt rise as DONE is entered; DONE lasts exactly one cycle.
      if (state_d == DONE) begin
        done_q <= 1'b1;
        if (hod_eff) halt_q <= 1'b1;
      end
    end
  end

`ifdef SIG_DUMP_CHECKSUM_EN
  always_ff @(posedge clk_i) begin
    if (rst_i || start)                   csum_q <= '0;
    else if (state_q == PUSH && sig_ready_i) csum_q <= csum_q + sig_data_q;
  end
`endif

  assign dev_rvalid_o = dev_rvalid_q;
  assign dev_rdata_o  = dev_rdata_q;
  assign dev_err_o    = dev_err_q;
  assign sig_addr_o   = sig_addr_q;
  assign sig_data_o   = sig_data_q;
  assign busy_o       = busy;
  assign halt_o       = halt_q;

endmodule

// File: tb/tb_sig_dump_ctrl.sv
// Randomized bench for sig_dump_ctrl with a transaction-level model: the
// model expands each start into the list of expected beats, tracks register
// contents, and checks the device response, stream beats, host requests,
// busy and halt on every cycle.
module tb_sig_dump_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i = 1'b1;
  logic        dev_req_i = 1'b0, dev_we_i = 1'b0;
  logic [31:0] dev_addr_i = '0, dev_wdata_i = '0;
  logic [3:0]  dev_be_i = '0;
  logic        dev_rvalid_o, dev_err_o;
  logic [31:0] dev_rdata_o;
  logic        host_req_o, host_gnt_i = 1'b0, host_rvalid_i = 1'b0;
  logic [31:0] host_addr_o, host_rdata_i = '0;
  logic        sig_valid_o, sig_ready_i = 1'b0;
  logic [31:0] sig_addr_o, sig_data_o;
  logic        busy_o, halt_o;

  sig_dump_ctrl #(.AddrWidth(32), .DataWidth(32)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .dev_req_i(dev_req_i), .dev_we_i(dev_we_i), .dev_addr_i(dev_addr_i),
    .dev_be_i(dev_be_i), .dev_wdata_i(dev_wdata_i),
    .dev_rvalid_o(dev_rvalid_o), .dev_rdata_o(dev_rdata_o), .dev_err_o(dev_err_o),
    .host_req_o(host_req_o), .host_gnt_i(host_gnt_i), .host_addr_o(host_addr_o),
    .host_rvalid_i(host_rvalid_i), .host_rdata_i(host_rdata_i),
    .sig_valid_o(sig_valid_o), .sig_ready_i(sig_ready_i),
    .sig_addr_o(sig_addr_o), .sig_data_o(sig_data_o),
    .busy_o(busy_o), .halt_o(halt_o)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    chk(nm, 32'(act), 32'(exp));
  endtask

  // RAM image: explicit preloads, otherwise an address-derived pattern.
  logic [31:0] mem [bit [31:0]];
  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  // ---------------- host RAM responder ----------------
  bit outst = 1'b0;
  int dly = 0;
  logic [31:0] oaddr = '0;
  initial begin
    bit g, rv_real, r;
    logic [31:0] ga;
    forever begin
      @(negedge clk);
      g = host_req_o && host_gnt_i; ga = host_addr_o;
      rv_real = host_rvalid_i && outst; r = rst_i;
      @(posedge clk); #1;
      if (r) outst = 1'b0;
      else begin
        if (rv_real) outst = 1'b0;
        if (g) begin outst = 1'b1; oaddr = ga; dly = $urandom_range(0, 3); end
      end
      host_gnt_i = ($urandom_range(0, 2) != 0);
      if (outst && dly == 0) begin
        host_rvalid_i = 1'b1; host_rdata_i = ram_rd(oaddr);
      end else begin
        if (outst) dly--;
        // stray rvalid pulses while nothing is outstanding must be ignored
        host_rvalid_i = !outst && ($urandom_range(0, 7) == 0);
        host_rdata_i  = $urandom();
      end
    end
  end

  // ---------------- harness ready ----------------
  int ready_mode = 1;   // 0 always ready, 1 random, 2 stall 2nd beat 5 cycles
  int stall_n = 0;
  logic [31:0] log_a[$], log_d[$];
  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0: sig_ready_i = 1'b1;
      2: if (log_a.size() == 1 && stall_n < 5 && sig_valid_o) begin
           sig_ready_i = 1'b0; stall_n++;
         end else sig_ready_i = 1'b1;
      default: sig_ready_i = ($urandom_range(0, 2) != 0);
    endcase
  end

  // ---------------- behavioural model + per-cycle compare ----------------
`ifdef SIG_DUMP_CHECKSUM_EN
  localparam int MAX_OFF = 4;
`else
  localparam int MAX_OFF = 3;
`endif
  logic [31:0] m_beg = '0, m_end = '0, m_csum = '0, e_rd = '0;
  bit m_done = 0, m_halt = 0, m_hod = 0, m_busy = 0, m_in_done = 0;
  bit m_live = 0, m_rst_chk = 0, e_rv = 0, e_err = 0, prev_stall = 0;
  logic [31:0] m_qa[$], m_qd[$];

  always @(negedge clk) begin : model
    bit busy_pre, hs, w_ok;
    int off;
    logic [31:0] a;
    if (m_live) begin
      if (m_rst_chk) begin
        chk("rst_ctl", {26'd0, host_req_o, sig_valid_o, dev_rvalid_o, dev_err_o, busy_o, halt_o}, 32'd0);
        chk("rst_haddr", host_addr_o, 32'd0);
        chk("rst_saddr", sig_addr_o, 32'd0);
        chk("rst_sdata", sig_data_o, 32'd0);
        chk("rst_rdata", dev_rdata_o, 32'd0);
      end
      chkb("dev_rvalid", dev_rvalid_o, e_rv);
      if (e_rv) begin
        chk("dev_rdata", dev_rdata_o, e_rd);
        chkb("dev_err", dev_err_o, e_err);
      end
      chkb("busy", busy_o, m_busy);
      chkb("halt", halt_o, m_halt);
      chkb("req_during_valid", host_req_o & sig_valid_o, 1'b0);
      chkb("req_outstanding", host_req_o & outst, 1'b0);
      if (m_qa.size() == 0) begin
        chkb("valid_no_beat", sig_valid_o, 1'b0);
        chkb("req_no_beat", host_req_o, 1'b0);
      end else begin
        if (sig_valid_o) begin
          chk("sig_addr", sig_addr_o, m_qa[0]);
          chk("sig_data", sig_data_o, m_qd[0]);
        end
        if (host_req_o) chk("host_addr", host_addr_o, m_qa[0]);
      end
      if (prev_stall) chkb("valid_held", sig_valid_o, 1'b1);
    end

    if (rst_i) begin
      m_live = 1; m_rst_chk = 1;
      m_beg = 0; m_end = 0; m_csum = 0; m_done = 0; m_halt = 0; m_hod = 0;
      m_busy = 0; m_in_done = 0; m_qa.delete(); m_qd.delete();
      e_rv = 0; e_rd = 0; e_err = 0; prev_stall = 0;
    end else if (m_live) begin
      m_rst_chk = 0;
      busy_pre = m_busy;
      off = int'(dev_addr_i[9:2]);
      e_rv = dev_req_i; e_err = 0; e_rd = '0;
      if (off > MAX_OFF) e_err = 1;
      else if (dev_we_i)
        e_err = (dev_be_i != 4'hF) || off == 3 || off == 4 || (off <= 1 && busy_pre);
      else case (off)
        0: e_rd = m_beg;
        1: e_rd = m_end;
        3: e_rd = {30'd0, m_done, busy_pre};
        4: e_rd = m_csum;
        default: e_rd = '0;
      endcase
      w_ok = dev_req_i && dev_we_i && !e_err;
      hs = sig_valid_o && sig_ready_i && m_qa.size() > 0;
      prev_stall = sig_valid_o && !sig_ready_i && m_qa.size() > 0;
      if (m_in_done) begin
        m_in_done = 0; m_busy = 0;
      end else if (hs) begin
        log_a.push_back(m_qa[0]); log_d.push_back(m_qd[0]);
        m_csum += m_qd.pop_front();
        void'(m_qa.pop_front());
        if (m_qa.size() == 0) begin m_in_done = 1; m_done = 1; m_halt |= m_hod; end
      end
      if (w_ok && off == 0) m_beg = dev_wdata_i & ~32'h3;
      if (w_ok && off == 1) m_end = dev_wdata_i & ~32'h3;
      if (w_ok && off == 2 && dev_wdata_i[0] && !busy_pre) begin
        m_hod = dev_wdata_i[1]; m_done = 0; m_csum = 0; m_busy = 1;
        a = m_beg;
        while (a < m_end && m_qa.size() < 4096) begin
          m_qa.push_back(a); m_qd.push_back(ram_rd(a)); a += 32'd4;
        end
        if (m_qa.size() == 0) begin m_in_done = 1; m_done = 1; m_halt |= m_hod; end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic acc(input bit we, input logic [9:0] off, input logic [3:0] be,
                     input logic [31:0] wd, output logic [31:0] rdv, output logic erv);
    logic [31:0] ad;
    @(posedge clk); #1;
    ad = $urandom(); ad[9:0] = off;
    dev_req_i = 1'b1; dev_we_i = we; dev_addr_i = ad; dev_be_i = be; dev_wdata_i = wd;
    @(posedge clk); #1;
    dev_req_i = 1'b0; dev_we_i = 1'b0;
    rdv = dev_rdata_o; erv = dev_err_o;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy_o) begin ok = 1; break; end
    end
    if (!ok) chkb("idle_timeout", busy_o, 1'b0);
  endtask

  task automatic check_abc(input string nm);
    chk({nm, "_beats"}, 32'(log_a.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < log_a.size()) begin
        chk({nm, "_addr"}, log_a[i], 32'h1000 + 32'(4 * i));
        chk({nm, "_data"}, log_d[i], 32'hA + 32'(i));
      end
  endtask

  initial begin
    logic [31:0] r;
    logic e;
    bit found;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;

    // register access and error responses
    acc(1, 10'h000, 4'hF, 32'h0000_2003, r, e);
    acc(0, 10'h000, 4'hF, 32'h0, r, e);
    chk("begin_rd", r, 32'h0000_2000); chkb("begin_err", e, 1'b0);
    acc(0, 10'h020, 4'hF, 32'h0, r, e);
    chk("unmapped_rd", r, 32'h0); chkb("unmapped_err", e, 1'b1);
    acc(1, 10'h00C, 4'hF, 32'h3, r, e);
    chkb("status_wr_err", e, 1'b1);
    acc(1, 10'h004, 4'h3, 32'h1234, r, e);
    chkb("partial_be_err", e, 1'b1);

    // basic three-word dump
    mem[32'h1000] = 32'hA; mem[32'h1004] = 32'hB; mem[32'h1008] = 32'hC;
    ready_mode = 0; log_a.delete(); log_d.delete();
    acc(1, 10'h000, 4'hF, 32'h1000, r, e);
    acc(1, 10'h004, 4'hF, 32'h100C, r, e);
    acc(1, 10'h008, 4'hF, 32'h1, r, e);
    wait_idle();
    check_abc("dump3");
    acc(0, 10'h00C, 4'hF, 32'h0, r, e);
    chk("status_done", r, 32'h2);

    // same dump with the second beat stalled
    ready_mode = 2; stall_n = 0; log_a.delete(); log_d.delete();
    acc(1, 10'h008, 4'hF, 32'h1, r, e);
    wait_idle();
    check_abc("stall");
    chk("stall_cycles", 32'(stall_n), 32'd5);

    // empty region
    log_a.delete(); log_d.delete();
    acc(1, 10'h000, 4'hF, 32'h2000, r, e);
    acc(1, 10'h004, 4'hF, 32'h2000, r, e);
    acc(1, 10'h008, 4'hF, 32'h1, r, e);
    acc(0, 10'h00C, 4'hF, 32'h0, r, e);
    chk("empty_status", r, 32'h2);
    chk("empty_beats", 32'(log_a.size()), 32'd0);

    // END write while busy is rejected
    ready_mode = 1;
    acc(1, 10'h000, 4'hF, 32'h3000, r, e);
    acc(1, 10'h004, 4'hF, 32'h3100, r, e);
    acc(1, 10'h008, 4'hF, 32'h1, r, e);
    acc(1, 10'h004, 4'hF, 32'h5000, r, e);
    chkb("end_busy_err", e, 1'b1);
    acc(0, 10'h004, 4'hF, 32'h0, r, e);
    chk("end_unchanged", r, 32'h3100);
    acc(1, 10'h008, 4'hF, 32'h1, r, e);
    chkb("start_busy_noerr", e, 1'b0);
    wait_idle();

    // halt on done, then reset in the middle of a read
    ready_mode = 0;
    acc(1, 10'h000, 4'hF, 32'h4000, r, e);
    acc(1, 10'h004, 4'hF, 32'h4008, r, e);
    acc(1, 10'h008, 4'hF, 32'h3, r, e);
    wait_idle();
    chkb("halt_set", halt_o, 1'b1);
    repeat (3) @(negedge clk);
    chkb("halt_sticky", halt_o, 1'b1);
    acc(1, 10'h008, 4'hF, 32'h1, r, e);
    found = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (host_req_o && host_gnt_i) begin found = 1; break; end
    end
    if (!found) chkb("grant_timeout", found, 1'b1);
    @(posedge clk); #1 rst_i = 1'b1;
    @(posedge clk); #1 rst_i = 1'b0;
    @(negedge clk);
    chkb("rst_halt", halt_o, 1'b0);
    chkb("rst_busy", busy_o, 1'b0);
    chkb("rst_valid", sig_valid_o, 1'b0);

    // checksum register
    mem[32'h6000] = 32'hFFFF_FFFF; mem[32'h6004] = 32'h2;
    ready_mode = 1;
    acc(1, 10'h000, 4'hF, 32'h6000, r, e);
    acc(1, 10'h004, 4'hF, 32'h6008, r, e);
    acc(1, 10'h008, 4'hF, 32'h1, r, e);
    wait_idle();
    acc(0, 10'h010, 4'hF, 32'h0, r, e);
`ifdef SIG_DUMP_CHECKSUM_EN
    chk("checksum", r, 32'h1); chkb("checksum_err", e, 1'b0);
`else
    chk("csum_unmapped_rd", r, 32'h0); chkb("csum_unmapped_err", e, 1'b1);
`endif

    // randomized dumps with concurrent register traffic
    for (int it = 0; it < 40; it++) begin
      logic [31:0] b, en;
      int nk;
      b = 32'h8000 + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: en = 32'h0;
        1: en = b;
        default: en = b + 32'($urandom_range(0, 64));
      endcase
      ready_mode = 1;
      acc(1, 10'h000, 4'hF, b, r, e);
      acc(1, 10'h004, 4'hF, en, r, e);
      acc(1, 10'h008, 4'hF, {30'd0, 1'($urandom_range(0, 1)), 1'b1}, r, e);
      nk = $urandom_range(0, 6);
      for (int k = 0; k < nk; k++)
        acc(1'($urandom_range(0, 1)), 10'($urandom_range(0, 27)),
            ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'hF, $urandom(), r, e);
      wait_idle();
    end

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
